sensor_frame_collector: RTL and testbench
=========================================

# sensor_frame_collector

- Collects per-sensor temperature readings arriving one at a time over a valid/ready stream.
- Assembles them into the packed frame the averaging path consumes: 8-bit temperature per sensor slot plus a per-slot enable.
- Sits upstream of the temperature averaging/display top and drives its sensor data and enable inputs.
- Publishes one complete frame per scan, holds it stable until downstream acknowledges, then starts the next scan.

## Interface
- NR_SENSORS, 200, number of sensor slots; 1..200.
- TEMP_W, 8, temperature width per slot; fixed at 8.

- clk_i  input  1  single clock; all logic rising-edge.
- rst_n_i  input  1  reset, synchronous, active-low.
- s_valid_i  input  1  reading beat valid.
- s_ready_o  output  1  collector accepts a beat.
- s_id_i  input  8  sensor slot index.
- s_temp_i  input  8  temperature, unsigned.
- s_last_i  input  1  final beat of the current scan.
- sensors_data_o  output  8*NR_SENSORS  packed frame; slot k at bits [8k+7:8k].
- sensors_en_o  output  NR_SENSORS  slot k enabled in published frame.
- active_cnt_o  output  8  number of enabled slots in published frame.
- frame_valid_o  output  1  published frame valid.
- frame_ready_i  input  1  downstream consumes the frame.
- bad_id_o  output  1  sticky: a beat with s_id_i >= NR_SENSORS was seen; cleared only by reset.

## Operation
- Two states:
  - COLLECT: s_ready_o=1.
  - HOLD: s_ready_o=0, frame_valid_o=1.
- Accept occurs when s_valid_i && s_ready_o.
- Internal shadow bank: NR_SENSORS data bytes, NR_SENSORS enable bits, 8-bit counter.
- Accepted beat with s_id_i < NR_SENSORS:
  - Writes shadow_data[id] = s_temp_i and sets shadow_en[id].
  - Counter increments only if shadow_en[id] was previously 0.
  - A duplicate id overwrites the temperature and does not recount.
- Accepted beat with s_id_i >= NR_SENSORS:
  - Shadow is unchanged; bad_id_o is set.
  - s_last_i on that beat is still honoured.
- Accepted beat with s_last_i=1:
  - The beat's own write, if valid, is included in the frame.
  - Shadow data, enables and counter are copied into the output registers.
  - Shadow enables and counter are cleared; shadow data need not be cleared.
  - State goes to HOLD.
- HOLD:
  - sensors_data_o, sensors_en_o and active_cnt_o are held stable.
  - Upstream stalls.
  - When frame_valid_o && frame_ready_i, state returns to COLLECT.
  - Output registers keep the last frame; only frame_valid_o drops.
- Empty scan (s_last_i on first beat with a bad id, or only bad ids):
  - Publishes sensors_en_o=0 and active_cnt_o=0.
  - Downstream guards divide-by-zero.
- s_temp_i, s_id_i and s_last_i are ignored when the beat is not accepted.
- Counter width: 8 bits, saturating is unnecessary since its maximum is 200.

## Timing
- Reset (rst_n_i low at a rising edge):
  - State=COLLECT; all shadow and output registers 0; frame_valid_o=0; bad_id_o=0.
  - s_ready_o is forced 0 while rst_n_i is low and becomes 1 the first cycle after release.
- Reset mid-scan or mid-HOLD: partial shadow and published frame are discarded; no frame is emitted.
- Publish latency: last beat accepted at edge t, so frame_valid_o=1 and new outputs are visible after edge t.
- Release: frame_ready_i sampled high with frame_valid_o at edge t, so frame_valid_o=0 and s_ready_o=1 after edge t.
  - The next beat can be accepted at edge t+1.
  - Minimum frame period is one HOLD cycle.
- frame_ready_i is allowed to be high before frame_valid_o; it has no effect in COLLECT.
- s_ready_o and frame_valid_o are decoded directly from the state register: no combinational path from s_valid_i or frame_ready_i to any output.
- Throughput in COLLECT: one beat per cycle.

## Structure
- Shared package temp_pkg holds:
  - NR_SENSORS_MAX=200 and TEMP_W=8.
  - Collector state encoding (COLLECT=1'b0, HOLD=1'b1).
  - Width of active count (8).
- One natural sub-module, sensor_shadow_bank, contains:
  - Indexed write of data and enable.
  - Already-enabled lookup for counting.
  - Clear-on-publish.
- The top owns the FSM, output registers and bad_id_o.

## Test plan
- Reset then 3 beats: ids 0/5/199, temps 20/30/40, last on id 199.
  - frame_valid_o=1 one cycle later.
  - Slots 0/5/199 = 20/30/40; sensors_en_o bits 0,5,199 set; active_cnt_o=3.
- Duplicate id 7, temps 10 then 55, last on second beat.
  - Slot 7=55, active_cnt_o=1.
- Beat id 200 temp 99 with last, NR_SENSORS=200.
  - bad_id_o=1 and stays 1; frame published with sensors_en_o=0 and active_cnt_o=0.
- Hold frame_ready_i=0 for 10 cycles with s_valid_i=1.
  - s_ready_o=0 throughout; outputs unchanged.
  - Raise frame_ready_i: next cycle frame_valid_o=0, s_ready_o=1; second frame does not include first frame's enables.
- All 200 ids back-to-back, temps equal to id mod 256, last on id 199.
  - active_cnt_o=200; every slot correct; 200 accepts in 200 cycles.
- Assert rst_n_i for one cycle mid-scan after 4 beats.
  - No frame_valid_o.
  - A following scan with only id 3 gives active_cnt_o=1 and no stale enables.

Source files
------------

// File: rtl/temp_pkg.sv
// temp_pkg: shared sizes, count width and collector state encoding for the temperature frame path.
package temp_pkg;
    localparam int NR_SENSORS_MAX = 200;
    localparam int TEMP_W         = 8;
    localparam int CNT_W          = 8;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } coll_state_e;
endpackage

// File: rtl/sensor_shadow_bank.sv
// sensor_shadow_bank: per-slot shadow storage filled one reading at a time, cleared on publish.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   wr_i                write an in-range reading this cycle
//   id_i, temp_i        slot index and temperature of the write
//   clr_i               publish: clear enables and count after this cycle
//   data_nx_o           shadow data including this cycle's write
//   en_nx_o             shadow enables including this cycle's write
//   cnt_nx_o            enabled-slot count including this cycle's write
module sensor_shadow_bank
    import temp_pkg::*;
#(
    parameter int NR_SENSORS = NR_SENSORS_MAX
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         wr_i,
    input  logic [7:0]                   id_i,
    input  logic [TEMP_W-1:0]            temp_i,
    input  logic                         clr_i,
    output logic [TEMP_W*NR_SENSORS-1:0] data_nx_o,
    output logic [NR_SENSORS-1:0]        en_nx_o,
    output logic [CNT_W-1:0]             cnt_nx_o
);
    logic [TEMP_W*NR_SENSORS-1:0] data_q;
    logic [NR_SENSORS-1:0]        en_q;
    logic [NR_SENSORS-1:0]        hit;
    logic [CNT_W-1:0]             cnt_q;
    logic                         first_hit;

    for (genvar k = 0; k < NR_SENSORS; k++) begin : g_slot
        assign hit[k] = wr_i && (int'(id_i) == k);
        assign data_nx_o[TEMP_W*k +: TEMP_W] = hit[k] ? temp_i : data_q[TEMP_W*k +: TEMP_W];
    end

    // A rewrite of an already-enabled slot updates its data but must not recount.
    assign first_hit = |(hit & ~en_q);
    assign en_nx_o   = en_q | hit;
    assign cnt_nx_o  = cnt_q + CNT_W'(first_hit);

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            data_q <= '0;
            en_q   <= '0;
            cnt_q  <= '0;
        end else begin
            data_q <= data_nx_o;
            en_q   <= clr_i ? '0 : en_nx_o;
            cnt_q  <= clr_i ? '0 : cnt_nx_o;
        end
    end
endmodule

// File: rtl/sensor_frame_collector.sv
// sensor_frame_collector: gathers per-sensor readings into a packed frame and publishes it until acknowledged.
// Ports:
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   s_valid_i/s_ready_o reading stream handshake; s_id_i, s_temp_i, s_last_i beat payload
//   sensors_data_o      published frame, slot k at [8k+7:8k]
//   sensors_en_o        per-slot enable of the published frame
//   active_cnt_o        number of enabled slots in the published frame
//   frame_valid_o       published frame valid; frame_ready_i releases it
//   bad_id_o            sticky flag for an out-of-range slot index
module sensor_frame_collector
    import temp_pkg::*;
#(
    parameter int NR_SENSORS = NR_SENSORS_MAX
) (
    input  logic                         clk_i,
    input  logic                         rst_n_i,
    input  logic                         s_valid_i,
    output logic                         s_ready_o,
    input  logic [7:0]                   s_id_i,
    input  logic [TEMP_W-1:0]            s_temp_i,
    input  logic                         s_last_i,
    output logic [TEMP_W*NR_SENSORS-1:0] sensors_data_o,
    output logic [NR_SENSORS-1:0]        sensors_en_o,
    output logic [CNT_W-1:0]             active_cnt_o,
    output logic                         frame_valid_o,
    input  logic                         frame_ready_i,
    output logic                         bad_id_o
);
    coll_state_e                  state_q, state_d;
    logic [TEMP_W*NR_SENSORS-1:0] data_q, data_nx;
    logic [NR_SENSORS-1:0]        en_q, en_nx;
    logic [CNT_W-1:0]             cnt_q, cnt_nx;
    logic                         bad_q;
    logic                         accept, id_ok, publish;

    assign s_ready_o     = rst_n_i && (state_q == COLLECT);
    assign frame_valid_o = (state_q == HOLD);
    assign accept        = s_valid_i && s_ready_o;
    assign id_ok         = int'(s_id_i) < NR_SENSORS;
    assign publish       = accept && s_last_i;

    sensor_shadow_bank #(
        .NR_SENSORS(NR_SENSORS)
    ) u_bank (
        .clk_i    (clk_i),
        .rst_n_i  (rst_n_i),
        .wr_i     (accept && id_ok),
        .id_i     (s_id_i),
        .temp_i   (s_temp_i),
        .clr_i    (publish),
        .data_nx_o(data_nx),
        .en_nx_o  (en_nx),
        .cnt_nx_o (cnt_nx)
    );

    always_comb begin
        state_d = state_q;
        state_d = (state_q == COLLECT) ? (publish ? HOLD : COLLECT)
                                       : (frame_ready_i ? COLLECT : HOLD);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= COLLECT;
            data_q  <= '0;
            en_q    <= '0;
            cnt_q   <= '0;
            bad_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bad_q   <= bad_q || (accept && !id_ok);
            // The bank's next values already include the closing beat's own write.
            if (publish) begin
                data_q <= data_nx;
                en_q   <= en_nx;
                cnt_q  <= cnt_nx;
            end
        end
    end

    assign sensors_data_o = data_q;
    assign sensors_en_o   = en_q;
    assign active_cnt_o   = cnt_q;
    assign bad_id_o       = bad_q;
endmodule

// File: tb/tb_sensor_frame_collector.sv
// tb_sensor_frame_collector: directed table-driven check of the frame collector plus multi-cycle sequences.
module tb_sensor_frame_collector;
    localparam int N = 200;

    logic           clk = 1'b0;
    logic           rst_n, s_valid, s_last, frame_ready;
    logic [7:0]     s_id, s_temp;
    logic           s_ready, frame_valid, bad_id;
    logic [8*N-1:0] sensors_data;
    logic [N-1:0]   sensors_en;
    logic [7:0]     active_cnt;

    int n_vec = 0;
    int n_err = 0;

    sensor_frame_collector #(.NR_SENSORS(N)) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .s_valid_i     (s_valid),
        .s_ready_o     (s_ready),
        .s_id_i        (s_id),
        .s_temp_i      (s_temp),
        .s_last_i      (s_last),
        .sensors_data_o(sensors_data),
        .sensors_en_o  (sensors_en),
        .active_cnt_o  (active_cnt),
        .frame_valid_o (frame_valid),
        .frame_ready_i (frame_ready),
        .bad_id_o      (bad_id)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       v;
        logic [7:0] id;
        logic [7:0] temp;
        logic       last;
        logic       fr;
        logic       rdy;
        logic       fv;
        int         cnt;
        logic       bad;
        int         slot;
        int         sdata;
        logic       sen;
    } vec_t;

    vec_t tbl[10];

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic drive(input logic v, input int id, input int temp, input logic last, input logic fr);
        s_valid     = v;
        s_id        = 8'(id);
        s_temp      = 8'(temp);
        s_last      = last;
        frame_ready = fr;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int acc;
        int nbad;
        tbl[0] = '{1'b1, 8'd0,   8'd20, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1, -1, 1'b0};
        tbl[1] = '{1'b1, 8'd5,   8'd30, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, -1, -1, 1'b0};
        tbl[2] = '{1'b1, 8'd199, 8'd40, 1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 199, 40, 1'b1};
        tbl[3] = '{1'b1, 8'd1,   8'd1,  1'b1, 1'b0, 1'b0, 1'b1, 3, 1'b0, 0,  20, 1'b1};
        tbl[4] = '{1'b0, 8'd0,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, 5,  30, 1'b1};
        tbl[5] = '{1'b1, 8'd7,   8'd10, 1'b0, 1'b1, 1'b1, 1'b0, 3, 1'b0, -1, -1, 1'b0};
        tbl[6] = '{1'b1, 8'd7,   8'd55, 1'b1, 1'b0, 1'b0, 1'b1, 1, 1'b0, 7,  55, 1'b1};
        tbl[7] = '{1'b0, 8'd0,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 1, 1'b0, 0,  -1, 1'b0};
        tbl[8] = '{1'b1, 8'd200, 8'd99, 1'b1, 1'b0, 1'b0, 1'b1, 0, 1'b1, 7,  -1, 1'b0};
        tbl[9] = '{1'b0, 8'd0,   8'd0,  1'b0, 1'b1, 1'b1, 1'b0, 0, 1'b1, -1, -1, 1'b0};

        rst_n = 1'b0;
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        step();
        step();
        chk("rst_ready_low", 32'(s_ready), 0);
        chk("rst_fv", 32'(frame_valid), 0);
        rst_n = 1'b1;
        step();
        chk("post_rst_ready", 32'(s_ready), 1);
        chk("post_rst_fv", 32'(frame_valid), 0);
        chk("post_rst_cnt", 32'(active_cnt), 0);
        chk("post_rst_bad", 32'(bad_id), 0);
        chk("post_rst_en_zero", 32'(sensors_en == '0), 1);
        chk("post_rst_data_zero", 32'(sensors_data == '0), 1);

        foreach (tbl[i]) begin
            drive(tbl[i].v, int'(tbl[i].id), int'(tbl[i].temp), tbl[i].last, tbl[i].fr);
            step();
            chk($sformatf("v%0d_ready", i), 32'(s_ready), 32'(tbl[i].rdy));
            chk($sformatf("v%0d_fv", i), 32'(frame_valid), 32'(tbl[i].fv));
            chk($sformatf("v%0d_cnt", i), 32'(active_cnt), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_bad", i), 32'(bad_id), 32'(tbl[i].bad));
            if (tbl[i].slot >= 0) begin
                chk($sformatf("v%0d_en%0d", i, tbl[i].slot), 32'(sensors_en[tbl[i].slot]), 32'(tbl[i].sen));
                if (tbl[i].sdata >= 0)
                    chk($sformatf("v%0d_data%0d", i, tbl[i].slot),
                        32'(sensors_data[8*tbl[i].slot +: 8]), 32'(tbl[i].sdata));
            end
        end
        chk("empty_frame_en_zero", 32'(sensors_en == '0), 1);

        // Long stall in HOLD with upstream still offering beats.
        drive(1'b1, 10, 77, 1'b1, 1'b0);
        step();
        chk("stall_pub_fv", 32'(frame_valid), 1);
        drive(1'b1, 11, 5, 1'b0, 1'b0);
        for (int c = 0; c < 10; c++) begin
            step();
            chk($sformatf("stall%0d_ready", c), 32'(s_ready), 0);
            chk($sformatf("stall%0d_fv", c), 32'(frame_valid), 1);
            chk($sformatf("stall%0d_data10", c), 32'(sensors_data[80 +: 8]), 77);
            chk($sformatf("stall%0d_cnt", c), 32'(active_cnt), 1);
        end
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();
        chk("release_fv", 32'(frame_valid), 0);
        chk("release_ready", 32'(s_ready), 1);
        drive(1'b1, 11, 5, 1'b1, 1'b0);
        step();
        chk("second_en10", 32'(sensors_en[10]), 0);
        chk("second_en11", 32'(sensors_en[11]), 1);
        chk("second_cnt", 32'(active_cnt), 1);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();

        // All slots back-to-back at full throughput.
        acc = 0;
        for (int i = 0; i < N; i++) begin
            drive(1'b1, i, i % 256, i == N - 1, 1'b0);
            if (s_ready) acc++;
            step();
        end
        chk("full_accepts", 32'(acc), 200);
        chk("full_fv", 32'(frame_valid), 1);
        chk("full_cnt", 32'(active_cnt), 200);
        chk("full_en_all", 32'(&sensors_en), 1);
        nbad = 0;
        for (int k = 0; k < N; k++)
            if (sensors_data[8*k +: 8] !== 8'(k)) nbad++;
        chk("full_slot_errors", 32'(nbad), 0);
        drive(1'b0, 0, 0, 1'b0, 1'b1);
        step();

        // Reset mid-scan discards the partial frame.
        foreach (tbl[i]) begin
            if (i < 4) begin
                drive(1'b1, 2 * i + 1, 60 + i, 1'b0, 1'b0);
                step();
            end
        end
        drive(1'b0, 0, 0, 1'b0, 1'b0);
        rst_n = 1'b0;
        step();
        chk("midrst_ready", 32'(s_ready), 0);
        chk("midrst_fv", 32'(frame_valid), 0);
        rst_n = 1'b1;
        step();
        chk("after_rst_fv", 32'(frame_valid), 0);
        chk("after_rst_ready", 32'(s_ready), 1);
        chk("after_rst_bad", 32'(bad_id), 0);
        chk("after_rst_cnt", 32'(active_cnt), 0);
        drive(1'b1, 3, 33, 1'b1, 1'b0);
        step();
        chk("id3_fv", 32'(frame_valid), 1);
        chk("id3_cnt", 32'(active_cnt), 1);
        chk("id3_en3", 32'(sensors_en[3]), 1);
        chk("id3_en_count", 32'($countones(sensors_en)), 1);
        chk("id3_data", 32'(sensors_data[24 +: 8]), 33);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
